wb_arbiter: RTL and testbench

Round-robin Wishbone (pipelined) bus arbiter that shares one `wb_slave` register block between `NUM_MASTERS` requesters.
- A master owns the slave port from grant until it drops its `cyc`.
- The arbiter counts outstanding strobes and enforces a cap on them.
- A watchdog aborts a bus cycle that has stopped getting responses, so a hung slave cannot lock the bus.
- It sits between the master-side interconnect and the slave register file.

---
 rtl/wb_arbiter_if.sv | 50 +++++
 rtl/wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the shared slave register block.
// The arbiter connects through the master modport (it masters the slave side and owns every output); the environment uses slave.
interface wb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int GRANULE     = 8
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

  // Handshake: a strobe is accepted in a cycle where stb is high and stall is low; each accepted
  // strobe is later terminated by exactly one ack or err, and a cycle ends when cyc falls.
  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
  logic [DATA_WIDTH-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic [NUM_MASTERS-1:0]            m_stall_o;
  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic [SEL_WIDTH-1:0]              s_sel_o;
  logic [DATA_WIDTH-1:0]             s_dat_i;
  logic                              s_ack_i;
  logic                              s_err_i;
  logic                              s_stall_i;
  logic [NUM_MASTERS-1:0]            gnt_o;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o, m_stall_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i, s_stall_i,
    output gnt_o
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o, m_stall_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i, s_stall_i,
    input  gnt_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin pipelined Wishbone arbiter: one owner at a time, capped outstanding strobes,
// and a watchdog that aborts a cycle whose slave has stopped responding.
module wb_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int GRANULE         = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_arbiter_if.master bus,
  output logic [1:0]   state_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       win, cand;
  logic                   win_found;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [3:0]             out_q, out_d;
  logic [15:0]            wd_q, wd_d;
  logic                   err_pend_q, err_pend_d;
  logic                   resp, cap, stb_c;

  assign state_o   = state_q;
  assign bus.gnt_o = gnt_q;

  // First requester strictly after the previous owner, wrapping; last_q doubles as the owner index.
  always_comb begin
    win       = last_q;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_MASTERS);
      if (!win_found && bus.m_cyc_i[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    out_d         = out_q;
    wd_d          = wd_q;
    err_pend_d    = 1'b0;
    resp          = 1'b0;
    cap           = 1'b0;
    stb_c         = 1'b0;
    bus.m_dat_o   = '0;
    bus.m_ack_o   = '0;
    bus.m_err_o   = '0;
    bus.m_stall_o = '1;
    bus.s_cyc_o   = 1'b0;
    bus.s_stb_o   = 1'b0;
    bus.s_we_o    = 1'b0;
    bus.s_adr_o   = '0;
    bus.s_dat_o   = '0;
    bus.s_sel_o   = '0;

    unique case (state_q)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          state_d    = GRANT;
          last_d     = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
        end
      end

      GRANT: begin
        // Responses only count against strobes actually in flight; stray ones are dropped.
        resp  = (out_q != 4'd0) && (bus.s_ack_i || bus.s_err_i);
        cap   = (out_q == 4'(MAX_OUTSTANDING)) && !resp;
        stb_c = bus.m_stb_i[last_q] && !cap;

        bus.s_cyc_o = bus.m_cyc_i[last_q];
        bus.s_stb_o = stb_c;
        bus.s_we_o  = bus.m_we_i[last_q];
        bus.s_adr_o = bus.m_adr_i[last_q*ADDR_WIDTH +: ADDR_WIDTH];
        bus.s_dat_o = bus.m_dat_i[last_q*DATA_WIDTH +: DATA_WIDTH];
        bus.s_sel_o = bus.m_sel_i[last_q*SEL_WIDTH +: SEL_WIDTH];
        bus.m_stall_o[last_q] = bus.s_stall_i || cap;
        if (out_q != 4'd0) begin
          bus.m_ack_o[last_q] = bus.s_ack_i;
          bus.m_err_o[last_q] = bus.s_err_i;
          bus.m_dat_o         = bus.s_dat_i;
        end

        out_d = out_q + {3'd0, stb_c && !bus.s_stall_i} - {3'd0, resp};
        wd_d  = ((out_q != 4'd0) && !resp) ? wd_q + 16'd1 : 16'd0;

        if (!bus.m_cyc_i[last_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          out_d   = '0;
          wd_d    = '0;
        end else if (wd_d == 16'(TIMEOUT_CYCLES)) begin
          state_d    = ABORT;
          out_d      = '0;
          wd_d       = '0;
          err_pend_d = 1'b1;
        end
      end

      ABORT: begin
        bus.m_err_o[last_q] = err_pend_q;
        out_d = '0;
        wd_d  = '0;
        if (!bus.m_cyc_i[last_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_MASTERS - 1);
      gnt_q      <= '0;
      out_q      <= '0;
      wd_q       <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      out_q      <= out_d;
      wd_q       <= wd_d;
      err_pend_q <= err_pend_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vector table for arbitration sequences, plus
// hand-written sequences for the outstanding cap, the watchdog abort and mid-transaction reset.
module tb_wb_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  wb_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8)) bus();

  wb_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8),
    .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .bus    (bus),
    .state_o(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "bench time limit");
  end

  // ---------------- per-master constants ----------------
  logic [AW-1:0] adr_c [N];
  logic [DW-1:0] dat_c [N];
  logic [SW-1:0] sel_c [N];
  logic [N-1:0]  we_c;
  logic [DW-1:0] rd_data;

  typedef struct {
    logic [N-1:0] cyc;
    logic [N-1:0] stb;
    logic         ack;
    logic [N-1:0] e_gnt;
    logic         e_scyc;
    logic         e_sstb;
    logic [N-1:0] e_stall;
    logic [N-1:0] e_ack;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [N-1:0] cyc, input logic [N-1:0] stb, input logic ack,
                              input logic [N-1:0] gnt, input logic scyc, input logic sstb,
                              input logic [N-1:0] stall, input logic [N-1:0] ack_o);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack;
    v.e_gnt = gnt; v.e_scyc = scyc; v.e_sstb = sstb; v.e_stall = stall; v.e_ack = ack_o;
    return v;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] oh);
    int r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] cyc, input logic [N-1:0] stb, input logic ack);
    bus.m_cyc_i   = cyc;
    bus.m_stb_i   = stb;
    bus.s_ack_i   = ack;
    bus.s_err_i   = 1'b0;
    bus.s_stall_i = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    int g;
    set_in(v.cyc, v.stb, v.ack);
    #2;
    chk("gnt_o", 64'(bus.gnt_o), 64'(v.e_gnt));
    chk("s_cyc_o", 64'(bus.s_cyc_o), 64'(v.e_scyc));
    chk("s_stb_o", 64'(bus.s_stb_o), 64'(v.e_sstb));
    chk("m_stall_o", 64'(bus.m_stall_o), 64'(v.e_stall));
    chk("m_ack_o", 64'(bus.m_ack_o), 64'(v.e_ack));
    chk("m_err_o", 64'(bus.m_err_o), 64'd0);
    if (v.e_gnt != '0) begin
      g = oh2idx(v.e_gnt);
      chk("s_adr_o", 64'(bus.s_adr_o), 64'(adr_c[g]));
      chk("s_dat_o", 64'(bus.s_dat_o), 64'(dat_c[g]));
      chk("s_sel_o", 64'(bus.s_sel_o), 64'(sel_c[g]));
      chk("s_we_o", 64'(bus.s_we_o), 64'(we_c[g]));
    end else begin
      chk("s_bus_idle", 64'({bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o}), 64'd0);
    end
    if (v.e_ack != '0) chk("m_dat_o", 64'(bus.m_dat_o), 64'(rd_data));
    tick();
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply_vec(vecs[i]);
  endtask

  // ---------------- test ----------------
  initial begin
    int a_lo, b_lo, c_lo, c_hi;
    int err_at;
    logic [N-1:0] own;

    adr_c   = '{16'h0100, 16'h0004, 16'h0208, 16'h030C};
    dat_c   = '{32'h1111_0000, 32'hDEAD_BEEF, 32'h2222_0002, 32'h3333_0003};
    sel_c   = '{4'h1, 4'hF, 4'h3, 4'hC};
    we_c    = 4'b1010;
    rd_data = 32'hC0FF_EE01;
    for (int i = 0; i < N; i++) begin
      bus.m_adr_i[i*AW +: AW] = adr_c[i];
      bus.m_dat_i[i*DW +: DW] = dat_c[i];
      bus.m_sel_i[i*SW +: SW] = sel_c[i];
    end
    bus.m_we_i  = we_c;
    bus.s_dat_i = rd_data;
    set_in('0, '0, 1'b0);

    // Seq A: masters 0 and 2 together straight after reset; 2 follows two cycles after 0 releases.
    a_lo = vecs.size();
    vecs.push_back(mk(4'b0101, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000));
    vecs.push_back(mk(4'b0101, 4'b0001, 0, 4'b0001, 1, 1, 4'b1110, 4'b0000));
    vecs.push_back(mk(4'b0101, 4'b0000, 1, 4'b0001, 1, 0, 4'b1110, 4'b0001));
    vecs.push_back(mk(4'b0100, 4'b0000, 0, 4'b0001, 0, 0, 4'b1110, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0100, 0, 4'b0100, 1, 1, 4'b1011, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 1, 4'b0100, 1, 0, 4'b1011, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b0100, 0, 0, 4'b1011, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000));
    // Seq B: single master 1 write of 0xDEADBEEF to 0x0004.
    b_lo = vecs.size();
    vecs.push_back(mk(4'b0010, 4'b0010, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000));
    vecs.push_back(mk(4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 4'b1101, 4'b0000));
    vecs.push_back(mk(4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 4'b1101, 4'b0010));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b0010, 0, 0, 4'b1101, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000));
    // Seq C: all four keep requesting, each owner releases after one transfer: order 0,1,2,3,0.
    c_lo = vecs.size();
    for (int m = 0; m < 5; m++) begin
      own = 4'b0001 << (m % N);
      vecs.push_back(mk(4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000));
      vecs.push_back(mk(4'b1111, own, 0, own, 1, 1, ~own, 4'b0000));
      vecs.push_back(mk(4'b1111, 4'b0000, 1, own, 1, 0, ~own, own));
      vecs.push_back(mk(4'b1111 & ~own, 4'b0000, 0, own, 0, 0, ~own, 4'b0000));
    end
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000));
    c_hi = vecs.size();

    // Reset values.
    #2;
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rst_stall", 64'(bus.m_stall_o), 64'hF);
    chk("rst_outputs", 64'({bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    tick();
    rst_n = 1'b1;

    run_vecs(a_lo, b_lo);
    run_vecs(b_lo, c_lo);

    // Outstanding cap with master 2: four strobes fill it, the fifth waits for the first ack.
    set_in(4'b0100, 4'b0000, 0); tick();
    for (int s = 0; s < 4; s++) begin
      set_in(4'b0100, 4'b0100, 0); #2;
      chk("cap_fill_stb", 64'(bus.s_stb_o), 64'd1);
      chk("cap_fill_stall", 64'(bus.m_stall_o), 64'hB);
      tick();
    end
    for (int s = 0; s < 2; s++) begin
      set_in(4'b0100, 4'b0100, 0); #2;
      chk("cap_blocked_stb", 64'(bus.s_stb_o), 64'd0);
      chk("cap_blocked_stall", 64'(bus.m_stall_o), 64'hF);
      tick();
    end
    set_in(4'b0100, 4'b0100, 1); #2;
    chk("cap_release_stb", 64'(bus.s_stb_o), 64'd1);
    chk("cap_release_stall", 64'(bus.m_stall_o), 64'hB);
    chk("cap_release_ack", 64'(bus.m_ack_o), 64'h4);
    chk("cap_release_rdata", 64'(bus.m_dat_o), 64'(rd_data));
    tick();
    set_in(4'b0100, 4'b0000, 1); #2;
    chk("ack_only", 64'(bus.m_ack_o), 64'h4);
    tick();
    set_in(4'b0100, 4'b0100, 0); #2;
    chk("out3_accepts", 64'(bus.s_stb_o), 64'd1);
    tick();
    set_in(4'b0100, 4'b0100, 0); #2;
    chk("out4_caps", 64'(bus.s_stb_o), 64'd0);
    tick();
    set_in(4'b0000, 4'b0000, 0); #2;
    chk("release_scyc", 64'(bus.s_cyc_o), 64'd0);
    tick();
    set_in(4'b0000, 4'b0000, 1); #2;
    chk("late_ack_dropped", 64'(bus.m_ack_o), 64'd0);
    chk("late_ack_state", 64'(state), 64'd0);
    tick();
    set_in(4'b0100, 4'b0000, 0); tick();
    set_in(4'b0100, 4'b0000, 1); #2;
    chk("regrant_gnt", 64'(bus.gnt_o), 64'h4);
    chk("ack_no_outstanding", 64'(bus.m_ack_o), 64'd0);
    tick();

    // Watchdog: one strobe accepted, slave silent for TIMEOUT_CYCLES=8 cycles, abort follows.
    set_in(4'b0100, 4'b0100, 0); #2;
    chk("wd_accept", 64'(bus.s_stb_o), 64'd1);
    tick();
    set_in(4'b0100, 4'b0000, 0);
    err_at = 0;
    for (int k = 1; k <= 30 && err_at == 0; k++) begin
      #2;
      if (bus.m_err_o[2]) err_at = k;
      else tick();
    end
    chk("wd_err_cycle", 64'(err_at), 64'd9);
    chk("abort_err", 64'(bus.m_err_o), 64'h4);
    chk("abort_scyc", 64'(bus.s_cyc_o), 64'd0);
    chk("abort_stall", 64'(bus.m_stall_o), 64'hF);
    chk("abort_state", 64'(state), 64'd2);
    tick();
    #2;
    chk("abort_err_single", 64'(bus.m_err_o), 64'd0);
    chk("abort_hold_gnt", 64'(bus.gnt_o), 64'h4);
    chk("abort_hold_scyc", 64'(bus.s_cyc_o), 64'd0);
    tick();
    set_in(4'b0000, 4'b0000, 0); #2;
    chk("abort_exit_state", 64'(state), 64'd2);
    tick();
    #2;
    chk("abort_idle_state", 64'(state), 64'd0);
    chk("abort_idle_gnt", 64'(bus.gnt_o), 64'd0);
    tick();

    // Reset during GRANT with two strobes outstanding on master 3.
    set_in(4'b1000, 4'b0000, 0); tick();
    for (int s = 0; s < 2; s++) begin
      set_in(4'b1000, 4'b1000, 0); #2;
      chk("pre_rst_stb", 64'(bus.s_stb_o), 64'd1);
      tick();
    end
    set_in(4'b1000, 4'b0000, 1); #2;
    chk("pre_rst_scyc", 64'(bus.s_cyc_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scyc", 64'(bus.s_cyc_o), 64'd0);
    chk("mid_rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("mid_rst_stall", 64'(bus.m_stall_o), 64'hF);
    chk("mid_rst_term", 64'({bus.m_ack_o, bus.m_err_o}), 64'd0);
    chk("mid_rst_state", 64'(state), 64'd0);
    tick();
    set_in(4'b0000, 4'b0000, 0);
    rst_n = 1'b1;

    // First grant after reset must go to master 0 (start of seq C).
    run_vecs(c_lo, c_hi);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
